tl_a_burst_buffer: RTL and testbench

//   Store-and-forward beat FIFO on the manager-side Channel A path. It sits between the
//   N->1 client socket output and the L2 request input.
//   It presents a message to L2 only after every beat of that message is buffered. L2

---
 rtl/tl_a_burst_buffer.sv | 137 +++++++++++++
 tb/tb_tl_a_burst_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_a_burst_buffer.sv
// Store-and-forward Channel A beat buffer: a message is offered to L2
// only once all of its beats are held, so bursts leave back-to-back.
module tl_a_burst_buffer #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64,
  parameter int M_SOURCE_W = 6,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [2:0]            in_opcode_i,
  input  logic [2:0]            in_param_i,
  input  logic [3:0]            in_size_i,
  input  logic [M_SOURCE_W-1:0] in_source_i,
  input  logic [ADDR_W-1:0]     in_address_i,
  input  logic [7:0]            in_mask_i,
  input  logic [DATA_W-1:0]     in_data_i,
  input  logic                  in_corrupt_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [2:0]            out_opcode_o,
  output logic [2:0]            out_param_o,
  output logic [3:0]            out_size_o,
  output logic [M_SOURCE_W-1:0] out_source_o,
  output logic [ADDR_W-1:0]     out_address_o,
  output logic [7:0]            out_mask_o,
  output logic [DATA_W-1:0]     out_data_o,
  output logic                  out_corrupt_o,
  output logic [CNT_W-1:0]      occupancy_o,
  output logic [CNT_W-1:0]      msg_count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [2:0]            opc_q  [DEPTH];
  logic [2:0]            par_q  [DEPTH];
  logic [3:0]            siz_q  [DEPTH];
  logic [M_SOURCE_W-1:0] src_q  [DEPTH];
  logic [ADDR_W-1:0]     adr_q  [DEPTH];
  logic [7:0]            msk_q  [DEPTH];
  logic [DATA_W-1:0]     dat_q  [DEPTH];
  logic                  cor_q  [DEPTH];

  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] occ, msgs;
  logic [2:0]       in_beat, out_beat;
  logic             live;
  logic             push, pop, in_last, out_last;

  function automatic logic is_multi(input logic [2:0] op);
    return (op == 3'd0) || (op == 3'd1);
  endfunction

  // Once past beat 0 a message is necessarily a burst, so the
  // beat-0 opcode alone decides framing.
  assign in_last  = (in_beat == 3'd0) ? !is_multi(in_opcode_i)
                                      : (in_beat == 3'd7);
  assign out_last = (out_beat == 3'd0) ? !is_multi(opc_q[rptr])
                                       : (out_beat == 3'd7);

  assign in_ready_o  = live && (occ < FULL);
  assign out_valid_o = (msgs != '0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  assign out_opcode_o  = opc_q[rptr];
  assign out_param_o   = par_q[rptr];
  assign out_size_o    = siz_q[rptr];
  assign out_source_o  = src_q[rptr];
  assign out_address_o = adr_q[rptr];
  assign out_mask_o    = msk_q[rptr];
  assign out_data_o    = dat_q[rptr];
  assign out_corrupt_o = cor_q[rptr];
  assign occupancy_o   = occ;
  assign msg_count_o   = msgs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        opc_q[i] <= '0;
        par_q[i] <= '0;
        siz_q[i] <= '0;
        src_q[i] <= '0;
        adr_q[i] <= '0;
        msk_q[i] <= '0;
        dat_q[i] <= '0;
        cor_q[i] <= 1'b0;
      end
    end else if (push) begin
      opc_q[wptr] <= in_opcode_i;
      par_q[wptr] <= in_param_i;
      siz_q[wptr] <= in_size_i;
      src_q[wptr] <= in_source_i;
      adr_q[wptr] <= in_address_i;
      msk_q[wptr] <= in_mask_i;
      dat_q[wptr] <= in_data_i;
      cor_q[wptr] <= in_corrupt_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live     <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      occ      <= '0;
      msgs     <= '0;
      in_beat  <= '0;
      out_beat <= '0;
    end else begin
      live <= 1'b1;
      if (push) begin
        wptr    <= wptr + PTR_W'(1);
        in_beat <= in_last ? 3'd0 : in_beat + 3'd1;
      end
      if (pop) begin
        rptr     <= rptr + PTR_W'(1);
        out_beat <= out_last ? 3'd0 : out_beat + 3'd1;
      end
      unique case ({push, pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
      unique case ({push && in_last, pop && out_last})
        2'b10:   msgs <= msgs + CNT_W'(1);
        2'b01:   msgs <= msgs - CNT_W'(1);
        default: msgs <= msgs;
      endcase
    end
  end

endmodule

// File: tb/tb_tl_a_burst_buffer.sv
// Directed bench for tl_a_burst_buffer: a vector table for the stalled
// burst plus hand-written sequences for the other corner cases.
module tb_tl_a_burst_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_opcode = '0;
  logic [2:0]  in_param = '0;
  logic [3:0]  in_size = '0;
  logic [5:0]  in_source = '0;
  logic [63:0] in_address = '0;
  logic [7:0]  in_mask = '0;
  logic [63:0] in_data = '0;
  logic        in_corrupt = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  out_opcode;
  logic [2:0]  out_param;
  logic [3:0]  out_size;
  logic [5:0]  out_source;
  logic [63:0] out_address;
  logic [7:0]  out_mask;
  logic [63:0] out_data;
  logic        out_corrupt;
  logic [4:0]  occupancy;
  logic [4:0]  msg_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tl_a_burst_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_opcode_i  (in_opcode),
    .in_param_i   (in_param),
    .in_size_i    (in_size),
    .in_source_i  (in_source),
    .in_address_i (in_address),
    .in_mask_i    (in_mask),
    .in_data_i    (in_data),
    .in_corrupt_i (in_corrupt),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_opcode_o (out_opcode),
    .out_param_o  (out_param),
    .out_size_o   (out_size),
    .out_source_o (out_source),
    .out_address_o(out_address),
    .out_mask_o   (out_mask),
    .out_data_o   (out_data),
    .out_corrupt_o(out_corrupt),
    .occupancy_o  (occupancy),
    .msg_count_o  (msg_count)
  );

  typedef struct {
    logic        v;
    logic [2:0]  op;
    logic [63:0] d;
    logic        rdy;
    logic        ev;
    logic [4:0]  eocc;
    logic [4:0]  emsg;
    logic [63:0] ed;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op,
                       input logic [63:0] d, input logic rdy);
    in_valid  = v;
    in_opcode = op;
    in_data   = d;
    out_ready = rdy;
  endtask

  function automatic vec_t mk(input logic v, input logic [2:0] op,
                              input logic [63:0] d, input logic rdy,
                              input logic ev, input int eocc,
                              input int emsg, input logic [63:0] ed);
    vec_t r;
    r.v = v; r.op = op; r.d = d; r.rdy = rdy;
    r.ev = ev; r.eocc = 5'(eocc); r.emsg = 5'(emsg); r.ed = ed;
    return r;
  endfunction

  initial begin
    // stalled PutFullData: 4 beats, 5 idle, 4 beats, then 8 pops
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 3'd0, 64'(i), 0, 0, i + 1, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 3'd0, 0, 0, 0, 4, 0, 0));
    for (int i = 4; i < 8; i++)
      vecs.push_back(mk(1, 3'd0, 64'(i), 0, i == 7, i + 1, i == 7, 0));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(0, 3'd4, 0, 1, k < 7, 7 - k, k < 7 ? 1 : 0,
                        64'(k + 1)));

    // reset state
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_msg", msg_count, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;
    #1;
    chk("pre_edge_in_ready", in_ready, 0);
    step();
    chk("post_rst_in_ready", in_ready, 1);

    // single beat Get
    in_address = 64'h1000;
    in_source  = 6'h2B;
    in_param   = 3'd2;
    in_size    = 4'd3;
    in_mask    = 8'hF0;
    drive(1, 3'd4, 64'hDEAD, 1);
    #1;
    chk("get_no_comb_path", out_valid, 0);
    step();
    drive(0, 3'd4, 0, 1);
    chk("get_valid", out_valid, 1);
    chk("get_opcode", out_opcode, 4);
    chk("get_addr", out_address, 64'h1000);
    chk("get_src", out_source, 6'h2B);
    chk("get_param", out_param, 2);
    chk("get_size", out_size, 3);
    chk("get_mask", out_mask, 8'hF0);
    chk("get_data", out_data, 64'hDEAD);
    step();
    chk("get_drained_occ", occupancy, 0);
    chk("get_drained_valid", out_valid, 0);

    // stalled burst table
    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].op, vecs[i].d, vecs[i].rdy);
      step();
      chk($sformatf("tbl%0d_valid", i), out_valid, vecs[i].ev);
      chk($sformatf("tbl%0d_occ", i), occupancy, vecs[i].eocc);
      chk($sformatf("tbl%0d_msg", i), msg_count, vecs[i].emsg);
      if (vecs[i].ev)
        chk($sformatf("tbl%0d_data", i), out_data, vecs[i].ed);
    end

    // full: two bursts with L2 stalled
    for (int i = 0; i < 16; i++) begin
      drive(1, 3'd0, 64'(100 + i), 0);
      step();
    end
    drive(0, 3'd0, 0, 0);
    chk("full_occ", occupancy, 16);
    chk("full_msg", msg_count, 2);
    chk("full_in_ready", in_ready, 0);
    chk("full_head", out_data, 100);
    drive(0, 3'd0, 0, 1);
    #1;
    chk("full_pop_same_cycle", in_ready, 0);
    step();
    drive(0, 3'd0, 0, 0);
    chk("after_pop_in_ready", in_ready, 1);
    chk("after_pop_occ", occupancy, 15);
    chk("after_pop_data", out_data, 101);
    drive(0, 3'd0, 0, 1);
    for (int i = 0; i < 15; i++) step();
    chk("full_drain_occ", occupancy, 0);
    chk("full_drain_msg", msg_count, 0);

    // concurrent single-beat stream across pointer wrap
    in_address = 64'd100;
    drive(1, 3'd4, 0, 0);
    step();
    for (int i = 0; i < 40; i++) begin
      in_address = 64'(200 + i);
      drive(1, 3'd4, 0, 1);
      chk($sformatf("cc%0d_addr", i), out_address,
          i == 0 ? 64'd100 : 64'(200 + i - 1));
      step();
      chk($sformatf("cc%0d_occ", i), occupancy, 1);
    end
    drive(0, 3'd4, 0, 1);
    chk("cc_last_addr", out_address, 239);
    step();
    chk("cc_drain_occ", occupancy, 0);

    // reset mid-burst
    for (int i = 0; i < 5; i++) begin
      drive(1, 3'd1, 64'(50 + i), 0);
      step();
    end
    drive(0, 3'd1, 0, 0);
    chk("mid_occ", occupancy, 5);
    rst = 1'b1;
    #1;
    chk("mrst_occ", occupancy, 0);
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_out_data", out_data, 0);
    step();
    rst = 1'b0;
    step();
    chk("mrst_in_ready_back", in_ready, 1);
    in_source = 6'h05;
    drive(1, 3'd4, 64'h77, 1);
    step();
    drive(0, 3'd4, 0, 1);
    chk("mrst_get_valid", out_valid, 1);
    chk("mrst_get_src", out_source, 5);
    chk("mrst_get_data", out_data, 64'h77);
    step();
    chk("mrst_get_msg", msg_count, 0);
    chk("mrst_get_occ", occupancy, 0);

    // opcode glitch on beat 3
    for (int i = 0; i < 8; i++) begin
      drive(1, i == 3 ? 3'd4 : 3'd0, 64'(i), 0);
      step();
      if (i == 3) chk("gl_msg_b3", msg_count, 0);
    end
    drive(0, 3'd0, 0, 1);
    chk("gl_msg", msg_count, 1);
    chk("gl_occ", occupancy, 8);
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 3) chk("gl_msg_pop3", msg_count, 1);
      if (k < 7) chk($sformatf("gl_pop%0d_valid", k), out_valid, 1);
    end
    chk("gl_end_msg", msg_count, 0);
    chk("gl_end_valid", out_valid, 0);
    chk("gl_end_occ", occupancy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
